shift_add_multiplier_n: RTL and testbench



---
 rtl/shift_add_multiplier_n_if.sv | 39 +++
 rtl/shift_add_multiplier_n.sv | 159 +++++++++++++++
 tb/tb_shift_add_multiplier_n.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_n_if.sv
// Operand/control inputs and product/status outputs of shift_add_multiplier_n.
// AhexDigits/BhexDigits exist only when MULT_HEX_DISPLAY_EN is defined.
interface shift_add_multiplier_n_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned HEX_W = 7 * (WIDTH / 4);

    logic             Run;
    logic             ClearA_LoadB;
    logic             Signed;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             Busy;
    logic             Done;
`ifdef MULT_HEX_DISPLAY_EN
    logic [HEX_W-1:0] AhexDigits;
    logic [HEX_W-1:0] BhexDigits;

    modport master (
        output Run, ClearA_LoadB, Signed, SW,
        input  Aval, Bval, Xval, Busy, Done, AhexDigits, BhexDigits
    );
    modport slave (
        input  Run, ClearA_LoadB, Signed, SW,
        output Aval, Bval, Xval, Busy, Done, AhexDigits, BhexDigits
    );
`else
    modport master (
        output Run, ClearA_LoadB, Signed, SW,
        input  Aval, Bval, Xval, Busy, Done
    );
    modport slave (
        input  Run, ClearA_LoadB, Signed, SW,
        output Aval, Bval, Xval, Busy, Done
    );
`endif
endinterface

// File: rtl/shift_add_multiplier_n.sv
// WIDTH-generic sequential shift-add multiplier (signed/unsigned), product in X:A:B.
// Optional registered 7-segment decode of A/B when MULT_HEX_DISPLAY_EN is defined.
module shift_add_multiplier_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    shift_add_multiplier_n_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADD   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_s, w_s_nxt;
    logic             r_x, w_x_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_signed, w_signed_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH:0]   w_ext_a, w_ext_s, w_sum;
    logic             w_last_iter;

    // Signed mode subtracts on the final iteration: the multiplier MSB has negative weight
    assign w_last_iter = (r_cnt == CW'(WIDTH - 1));
    assign w_ext_a     = r_signed ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
    assign w_ext_s     = r_signed ? {r_s[WIDTH-1], r_s} : {1'b0, r_s};
    assign w_sum       = (r_signed && w_last_iter) ? (w_ext_a - w_ext_s) : (w_ext_a + w_ext_s);

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_s_nxt      = r_s;
        w_x_nxt      = r_x;
        w_cnt_nxt    = r_cnt;
        w_signed_nxt = r_signed;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.ClearA_LoadB) begin
                    w_a_nxt = '0;
                    w_x_nxt = 1'b0;
                    w_b_nxt = bus.SW;
                end else if (!bus.Run) begin
                    w_s_nxt      = bus.SW;
                    w_signed_nxt = bus.Signed;
                    w_a_nxt      = '0;
                    w_x_nxt      = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_ADD;
                end
            end
            ST_ADD: begin
                if (r_b[0]) begin
                    w_x_nxt = w_sum[WIDTH];
                    w_a_nxt = w_sum[WIDTH-1:0];
                end
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_a_nxt     = {r_x, r_a[WIDTH-1:1]};
                w_b_nxt     = {r_a[0], r_b[WIDTH-1:1]};
                w_x_nxt     = r_signed ? r_x : 1'b0;
                w_cnt_nxt   = r_cnt + CW'(1);
                w_state_nxt = w_last_iter ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                if (bus.Run) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == ST_ADD) || (w_state_nxt == ST_SHIFT);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= '0;
            r_x      <= 1'b0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_s      <= w_s_nxt;
            r_x      <= w_x_nxt;
            r_cnt    <= w_cnt_nxt;
            r_signed <= w_signed_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.Aval = r_a;
    assign bus.Bval = r_b;
    assign bus.Xval = r_x;
    assign bus.Busy = r_busy;
    assign bus.Done = r_done;

`ifdef MULT_HEX_DISPLAY_EN
    localparam int unsigned NDIG = WIDTH / 4;

    logic [7*NDIG-1:0] r_ahex;
    logic [7*NDIG-1:0] r_bhex;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Decoded from the registered A/B, so the digits trail Aval/Bval by one cycle
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_ahex <= {NDIG{7'b1000000}};
            r_bhex <= {NDIG{7'b1000000}};
        end else begin
            for (int i = 0; i < int'(NDIG); i++) begin
                r_ahex[i*7 +: 7] <= seg7(r_a[i*4 +: 4]);
                r_bhex[i*7 +: 7] <= seg7(r_b[i*4 +: 4]);
            end
        end
    end

    assign bus.AhexDigits = r_ahex;
    assign bus.BhexDigits = r_bhex;
`endif

endmodule

// File: tb/tb_shift_add_multiplier_n.sv
// Self-checking bench for shift_add_multiplier_n against an arithmetic product model.
module tb_shift_add_multiplier_n;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W + 1;
    localparam int          LAT = 2 * W;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;
    logic [W-1:0] model_b;

    shift_add_multiplier_n_if #(.WIDTH(W)) bus ();

    shift_add_multiplier_n #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Reference product {X,A,B}: sign-extended when signed, X=0 when unsigned
    function automatic logic [PW-1:0] model(input logic [W-1:0] b, input logic [W-1:0] s,
                                            input logic sgn);
        longint p;
        if (sgn) p = longint'($signed(b)) * longint'($signed(s));
        else     p = longint'(b) * longint'(s);
        return PW'(p);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] b);
        bus.ClearA_LoadB = 1'b0;
        bus.SW           = b;
        tick();
        bus.ClearA_LoadB = 1'b1;
        model_b          = b;
    endtask

    // Runs one multiply from IDLE and returns to IDLE; reports result, latency, status sanity
    task automatic run_op(input logic [W-1:0] s, input logic sgn, input logic chg_sw,
                          output logic [PW-1:0] res, output int lat, output logic stat_ok);
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b1;
        bus.SW           = s;
        bus.Signed       = sgn;
        tick();
        bus.Run = 1'b1;
        if (chg_sw) begin
            bus.SW     = W'($urandom);
            bus.Signed = ~sgn;
        end
        stat_ok = (bus.Busy === 1'b1) && (bus.Done === 1'b0);
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 4 * LAT) begin
            tick();
            lat++;
            if (bus.Done !== 1'b1 && bus.Busy !== 1'b1) stat_ok = 1'b0;
            if (chg_sw) bus.SW = W'($urandom);
        end
        res = {bus.Xval, bus.Aval, bus.Bval};
        if (bus.Busy !== 1'b0) stat_ok = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.Xval, bus.Aval, bus.Bval} !== '0) begin
            n_errors++;
            $display("FAIL reset_xab got=%h exp=0", {bus.Xval, bus.Aval, bus.Bval});
        end
        n_checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_status got=%b exp=00", {bus.Busy, bus.Done});
        end
`ifdef MULT_HEX_DISPLAY_EN
        n_checks++;
        if ({bus.AhexDigits, bus.BhexDigits} !== {4{7'b1000000}}) begin
            n_errors++;
            $display("FAIL reset_hex got=%h", {bus.AhexDigits, bus.BhexDigits});
        end
`endif
        Reset = 1'b1;
        tick();
        model_b = '0;
    endtask

    task automatic test_plan_vectors();
        logic [PW-1:0] res;
        int            lat;
        logic          ok;
        do_load(8'h03);
        run_op(8'hFD, 1'b1, 1'b0, res, lat, ok);
        n_checks++;
        if (res !== 17'h1FFF7) begin
            n_errors++;
            $display("FAIL signed_3x-3 got=%h exp=1fff7", res);
        end
        n_checks++;
        if (lat !== LAT || ok !== 1'b1) begin
            n_errors++;
            $display("FAIL signed_latency got=%0d/%b exp=%0d/1", lat, ok, LAT);
        end
        run_op(8'h03, 1'b1, 1'b0, res, lat, ok);
        n_checks++;
        if (res !== 17'h1FFE5) begin
            n_errors++;
            $display("FAIL chained_-9x3 got=%h exp=1ffe5", res);
        end
        do_load(8'h03);
        run_op(8'hFD, 1'b0, 1'b0, res, lat, ok);
        n_checks++;
        if (res !== 17'h002F7) begin
            n_errors++;
            $display("FAIL unsigned_3xFD got=%h exp=002f7", res);
        end
        do_load(8'h80);
        run_op(8'h80, 1'b1, 1'b1, res, lat, ok);
        n_checks++;
        if (res !== 17'h04000) begin
            n_errors++;
            $display("FAIL signed_min_sq_swchg got=%h exp=04000", res);
        end
        model_b = res[W-1:0];
    endtask

    task automatic test_random();
        logic [PW-1:0] res, exp;
        logic [W-1:0]  s;
        logic          sgn, chg;
        int            lat;
        logic          ok;
        int            bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_load(W'($urandom));
            s   = W'($urandom);
            sgn = 1'($urandom);
            chg = 1'($urandom);
            exp = model(model_b, s, sgn);
            run_op(s, sgn, chg, res, lat, ok);
            n_checks++;
            if (res !== exp || lat !== LAT || ok !== 1'b1) begin
                n_errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random[%0d] b=%h s=%h sgn=%b got=%h/%0d/%b exp=%h/%0d/1",
                             i, model_b, s, sgn, res, lat, ok, exp, LAT);
            end
            model_b = exp[W-1:0];
        end
    endtask

    task automatic test_reset_mid();
        do_load(8'h5A);
        bus.Run    = 1'b0;
        bus.SW     = 8'hC3;
        bus.Signed = 1'b1;
        tick();
        bus.Run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        n_checks++;
        if ({bus.Xval, bus.Aval, bus.Bval, bus.Busy, bus.Done} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid got=%h exp=0",
                     {bus.Xval, bus.Aval, bus.Bval, bus.Busy, bus.Done});
        end
        model_b = '0;
        tick();
        n_checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_mid_idle got=%b exp=00", {bus.Busy, bus.Done});
        end
    endtask

    task automatic test_run_held();
        logic [PW-1:0] exp, held;
        int            lat;
        logic          ok;
        do_load(8'h07);
        exp        = model(8'h07, 8'h09, 1'b0);
        bus.Run    = 1'b0;
        bus.SW     = 8'h09;
        bus.Signed = 1'b0;
        tick();
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 4 * LAT) begin
            tick();
            lat++;
        end
        held = {bus.Xval, bus.Aval, bus.Bval};
        n_checks++;
        if (held !== exp || lat !== LAT) begin
            n_errors++;
            $display("FAIL run_held_result got=%h/%0d exp=%h/%0d", held, lat, exp, LAT);
        end
        ok = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 ||
                {bus.Xval, bus.Aval, bus.Bval} !== exp) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL run_held_no_restart got=%b exp=1", ok);
        end
        bus.Run = 1'b1;
        tick();
        n_checks++;
        if ({bus.Busy, bus.Done} !== 2'b00) begin
            n_errors++;
            $display("FAIL run_release_idle got=%b exp=00", {bus.Busy, bus.Done});
        end
        model_b = exp[W-1:0];
    endtask

    task automatic test_load_and_run();
        logic [PW-1:0] res, exp;
        int            lat;
        bus.ClearA_LoadB = 1'b0;
        bus.Run          = 1'b0;
        bus.SW           = 8'h55;
        bus.Signed       = 1'b0;
        tick();
        n_checks++;
        if (bus.Bval !== 8'h55 || bus.Busy !== 1'b0) begin
            n_errors++;
            $display("FAIL load_priority got=%h/%b exp=55/0", bus.Bval, bus.Busy);
        end
        bus.ClearA_LoadB = 1'b1;
        bus.SW           = 8'h0A;
        tick();
        n_checks++;
        if (bus.Busy !== 1'b1) begin
            n_errors++;
            $display("FAIL start_after_load got=%b exp=1", bus.Busy);
        end
        bus.Run = 1'b1;
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 4 * LAT) begin
            tick();
            lat++;
        end
        res = {bus.Xval, bus.Aval, bus.Bval};
        exp = model(8'h55, 8'h0A, 1'b0);
        n_checks++;
        if (res !== exp || lat !== LAT) begin
            n_errors++;
            $display("FAIL load_run_product got=%h/%0d exp=%h/%0d", res, lat, exp, LAT);
        end
        tick();
        model_b = exp[W-1:0];
    endtask

`ifdef MULT_HEX_DISPLAY_EN
    task automatic test_hex();
        logic [PW-1:0] res;
        int            lat;
        logic          ok;
        do_load(8'h03);
        run_op(8'hFD, 1'b1, 1'b0, res, lat, ok);
        n_checks++;
        if (bus.AhexDigits !== {2{7'b0001110}}) begin
            n_errors++;
            $display("FAIL hex_a_FF got=%b", bus.AhexDigits);
        end
        n_checks++;
        if (bus.BhexDigits !== {7'b0001110, 7'b1111000}) begin
            n_errors++;
            $display("FAIL hex_b_F7 got=%b", bus.BhexDigits);
        end
        model_b = res[W-1:0];
    endtask
`endif

    initial begin
        Clk              = 1'b0;
        Reset            = 1'b0;
        n_checks         = 0;
        n_errors         = 0;
        model_b          = '0;
        bus.Run          = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        bus.Signed       = 1'b0;
        bus.SW           = '0;
        test_reset();
        test_plan_vectors();
        test_random();
        test_reset_mid();
        test_run_held();
        test_load_and_run();
`ifdef MULT_HEX_DISPLAY_EN
        test_hex();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
